// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable width, parity and rate, feeding a
// small valid/ready FIFO that carries per-character parity and framing flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 brk,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 2;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if (DIV < 1) begin : gBadDiv
    $error("uart_rx_fifo: CLK_FREQ too low for BAUD*OVERSAMPLE");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : gBadOs
    $error("uart_rx_fifo: OVERSAMPLE must be a power of 2 in 8..32");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadBits
    $error("uart_rx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : gBadPar
    $error("uart_rx_fifo: PARITY must be 0, 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2 in 2..64");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRKWAIT} state_t;

  logic [DW-1:0]        divCnt;
  logic                 tick;
  logic                 rxdSync_p0, rxdSync_p1;
  logic                 rxS;
  state_t               state;
  logic [CW-1:0]        smpCnt;
  logic [BW-1:0]        bitIdx;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parBit, perrBit;
  logic                 bitEnd, pushReq, isBreak, pushPerr;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]          wrPtr, rdPtr, wrNext, rdNext;
  logic                 full, pop, doPush;
  logic [EW-1:0]        pushEntry, headNext;

  // Free-running oversample tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt <= '0;
    end else if (tick) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + DW'(1);
    end
  end

  assign tick = (divCnt == DIV_LAST);

  // Synchroniser stages (idle-high so reset does not look like a start bit)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxdSync_p0 <= 1'b1;
      rxdSync_p1 <= 1'b1;
    end else begin
      rxdSync_p0 <= rxd;
      rxdSync_p1 <= rxdSync_p0;
    end
  end

  assign rxS     = rxdSync_p1;
  assign bitEnd  = tick && (smpCnt == OS_LAST);
  assign pushReq = bitEnd && (state == STOP);
  assign isBreak = (shiftReg == '0) && !rxS && ((PARITY == 0) || !parBit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      smpCnt  <= '0;
      bitIdx  <= '0;
      brk     <= 1'b0;
      rx_busy <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!rxS) begin
            smpCnt  <= '0;
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (smpCnt == HALF_LAST) begin
            smpCnt <= '0;
            bitIdx <= '0;
            if (rxS) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            smpCnt <= smpCnt + CW'(1);
          end
        end
        DATA: begin
          if (smpCnt == OS_LAST) begin
            smpCnt <= '0;
            if (bitIdx == BIT_LAST) begin
              state <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bitIdx <= bitIdx + BW'(1);
            end
          end else begin
            smpCnt <= smpCnt + CW'(1);
          end
        end
        PAR: begin
          if (smpCnt == OS_LAST) begin
            smpCnt <= '0;
            state  <= STOP;
          end else begin
            smpCnt <= smpCnt + CW'(1);
          end
        end
        STOP: begin
          if (smpCnt == OS_LAST) begin
            smpCnt <= '0;
            // An all-zero frame including stop is a break; hold off until the line idles
            if (isBreak) begin
              brk   <= 1'b1;
              state <= BRKWAIT;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            smpCnt <= smpCnt + CW'(1);
          end
        end
        BRKWAIT: begin
          if (rxS) begin
            brk     <= 1'b0;
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Character assembly: LSB-first shift, parity captured with its error flag
  always_ff @(posedge clk) begin
    if (bitEnd && state == DATA) begin
      shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
    end
    if (bitEnd && state == PAR) begin
      parBit  <= rxS;
      perrBit <= (^{shiftReg, rxS}) ^ (PARITY == 1);
    end
  end

  assign pushPerr  = (PARITY != 0) && perrBit;
  assign pushEntry = {pushPerr, ~rxS, shiftReg};

  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign pop    = m_valid && m_ready;
  assign doPush = pushReq && (!full || pop);
  assign wrNext = wrPtr + {{AW{1'b0}}, doPush};
  assign rdNext = rdPtr + {{AW{1'b0}}, pop};

  // Next head value; bypass the memory when the incoming entry becomes the head
  always_comb begin
    headNext = '0;
    if (wrNext != rdNext) begin
      if (doPush && (wrPtr[AW-1:0] == rdNext[AW-1:0])) begin
        headNext = pushEntry;
      end else begin
        headNext = mem[rdNext[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr[AW-1:0]] <= pushEntry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      m_valid <= 1'b0;
      m_perr  <= 1'b0;
      m_ferr  <= 1'b0;
      m_data  <= '0;
      overrun <= 1'b0;
    end else begin
      wrPtr                    <= wrNext;
      rdPtr                    <= rdNext;
      m_valid                  <= (wrNext != rdNext);
      {m_perr, m_ferr, m_data} <= headNext;
      overrun                  <= pushReq && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 and a 7E1 instance driven with directed and
// random frames, checked against an expected-character queue.
module tb_uart_rx_fifo;

  localparam int CLKF   = 1843200;
  localparam int BAUDR  = 115200;
  localparam int OS     = 16;
  localparam int BITCLK = CLKF / BAUDR;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxdA, rdyA, vA, perrA, ferrA, brkA, ovrA, busyA;
  logic [7:0] dataA;
  logic       rxdB, rdyB, vB, perrB, ferrB, brkB, ovrB, busyB;
  logic [6:0] dataB;

  logic [9:0] gotA[$];
  logic [8:0] gotB[$];
  logic [9:0] expA[$];
  logic [8:0] expB[$];
  int ovrCntA = 0;
  int ovrCntB = 0;
  int vCycA   = 0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(0), .FIFO_DEPTH(4)) dutA (
    .clk(clk), .rst(rst), .rxd(rxdA), .m_data(dataA), .m_perr(perrA), .m_ferr(ferrA),
    .m_valid(vA), .m_ready(rdyA), .brk(brkA), .overrun(ovrA), .rx_busy(busyA));

  uart_rx_fifo #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .OVERSAMPLE(OS), .DATA_BITS(7),
                 .PARITY(2), .FIFO_DEPTH(4)) dutB (
    .clk(clk), .rst(rst), .rxd(rxdB), .m_data(dataB), .m_perr(perrB), .m_ferr(ferrB),
    .m_valid(vB), .m_ready(rdyB), .brk(brkB), .overrun(ovrB), .rx_busy(busyB));

  // Consumer-side monitor
  always @(negedge clk) begin
    if (vA && rdyA) gotA.push_back({perrA, ferrA, dataA});
    if (vB && rdyB) gotB.push_back({perrB, ferrB, dataB});
    if (ovrA) ovrCntA++;
    if (ovrB) ovrCntB++;
    if (vA) vCycA++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] modelA(input logic [7:0] d, input logic stop);
    return {1'b0, ~stop, d};
  endfunction

  // Even parity: error whenever data plus parity bit hold an odd count of ones
  function automatic logic [8:0] modelB(input logic [6:0] d, input logic p, input logic stop);
    logic perr;
    perr = ((($countones(d) + int'(p)) % 2) != 0);
    return {perr, ~stop, d};
  endfunction

  task automatic driveBit(input int ch, input logic b);
    @(negedge clk);
    if (ch == 0) rxdA = b;
    else rxdB = b;
    repeat (BITCLK - 1) @(negedge clk);
  endtask

  task automatic sendFrame(input int ch, input logic [8:0] d, input int nb,
                           input bit hasPar, input logic par, input logic stop);
    driveBit(ch, 1'b0);
    for (int i = 0; i < nb; i++) driveBit(ch, d[i]);
    if (hasPar) driveBit(ch, par);
    driveBit(ch, stop);
    driveBit(ch, 1'b1);
    driveBit(ch, 1'b1);
  endtask

  task automatic popA(input string tag, input logic [9:0] exp);
    logic [31:0] obs;
    obs = (gotA.size() > 0) ? 32'(gotA.pop_front()) : 32'hDEADBEEF;
    chk(tag, obs, 32'(exp));
  endtask

  task automatic popB(input string tag, input logic [8:0] exp);
    logic [31:0] obs;
    obs = (gotB.size() > 0) ? 32'(gotB.pop_front()) : 32'hDEADBEEF;
    chk(tag, obs, 32'(exp));
  endtask

  initial begin
    logic [7:0] d8;
    logic [6:0] d7;
    logic       st, pb;
    int         base;

    rst = 1'b1; rxdA = 1'b1; rxdB = 1'b1; rdyA = 1'b0; rdyB = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs_A", 32'({vA, perrA, ferrA, brkA, ovrA, busyA, dataA}), 32'd0);
    chk("reset_outs_B", 32'({vB, perrB, ferrB, brkB, ovrB, busyB, dataB}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 single character, consumer always ready
    rdyA = 1'b1; rdyB = 1'b1;
    base = vCycA;
    sendFrame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    chk("t1_count", 32'(gotA.size()), 32'd1);
    popA("t1_entry", 10'h0A5);
    chk("t1_valid_cycles", 32'(vCycA - base), 32'd1);
    chk("t1_no_overrun", 32'(ovrCntA), 32'd0);

    // Random 8N1 frames, some with a bad stop bit
    for (int n = 0; n < 10; n++) begin
      d8 = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      expA.push_back(modelA(d8, st));
      sendFrame(0, {1'b0, d8}, 8, 1'b0, 1'b0, st);
    end
    repeat (32) @(negedge clk);
    chk("rndA_count", 32'(gotA.size()), 32'(expA.size()));
    while (expA.size() > 0) popA("rndA_entry", expA.pop_front());

    // 7E1 directed parity cases
    sendFrame(1, 9'h041, 7, 1'b1, 1'b0, 1'b1);
    sendFrame(1, 9'h041, 7, 1'b1, 1'b1, 1'b1);
    repeat (16) @(negedge clk);
    popB("t2_par_ok", 9'h041);
    popB("t2_par_bad", 9'h141);

    // Random 7E1 frames with random parity bits
    for (int n = 0; n < 10; n++) begin
      d7 = 7'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 3) != 0);
      expB.push_back(modelB(d7, pb, st));
      sendFrame(1, {2'b00, d7}, 7, 1'b1, pb, st);
    end
    repeat (32) @(negedge clk);
    chk("rndB_count", 32'(gotB.size()), 32'(expB.size()));
    while (expB.size() > 0) popB("rndB_entry", expB.pop_front());
    chk("rndB_no_overrun", 32'(ovrCntB), 32'd0);

    // Fill the FIFO with the consumer stalled
    rdyA = 1'b0;
    base = ovrCntA;
    for (int n = 1; n <= 5; n++) sendFrame(0, 9'(n), 8, 1'b0, 1'b0, 1'b1);
    chk("t3_overrun_pulses", 32'(ovrCntA - base), 32'd1);
    chk("t3_valid_held", 32'(vA), 32'd1);
    chk("t3_nothing_popped", 32'(gotA.size()), 32'd0);
    rdyA = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3_drained", 32'(gotA.size()), 32'd4);
    for (int n = 1; n <= 4; n++) popA("t3_entry", 10'(n));
    chk("t3_empty", 32'(vA), 32'd0);

    // Break: line low for 20 bit times
    @(negedge clk) rxdA = 1'b0;
    repeat (20 * BITCLK - 1) @(negedge clk);
    chk("t4_brk_set", 32'(brkA), 32'd1);
    chk("t4_busy", 32'(busyA), 32'd1);
    rxdA = 1'b1;
    @(negedge clk);
    chk("t4_brk_held", 32'(brkA), 32'd1);
    repeat (4) @(negedge clk);
    chk("t4_brk_clear", 32'(brkA), 32'd0);
    repeat (100) @(negedge clk);
    chk("t4_count", 32'(gotA.size()), 32'd1);
    popA("t4_entry", 10'h100);
    chk("t4_idle", 32'(busyA), 32'd0);

    // Short glitch: false start
    @(negedge clk) rxdA = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy_in_start", 32'(busyA), 32'd1);
    rxdA = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_idle", 32'(busyA), 32'd0);
    chk("t5_no_entry", 32'(gotA.size()), 32'd0);
    chk("t5_no_valid", 32'(vA), 32'd0);

    // Reset in the middle of data bit 4 of 0x3C
    d8 = 8'h3C;
    driveBit(0, 1'b0);
    for (int i = 0; i < 4; i++) driveBit(0, d8[i]);
    @(negedge clk) rxdA = d8[4];
    repeat (7) @(negedge clk);
    chk("t6_busy_before_rst", 32'(busyA), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_outs_in_reset_A", 32'({vA, perrA, ferrA, brkA, ovrA, busyA, dataA}), 32'd0);
    chk("t6_outs_in_reset_B", 32'({vB, perrB, ferrB, brkB, ovrB, busyB, dataB}), 32'd0);
    rxdA = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    sendFrame(0, 9'h07E, 8, 1'b0, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    chk("t6_count", 32'(gotA.size()), 32'd1);
    popA("t6_entry", 10'h07E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
